// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-field helpers for the data cache.
package dcache_pkg;

   typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

   localparam int LINE_BYTES        = 16;
   localparam int WORDS_PER_LINE    = 4;
   localparam int OFFSET_W          = $clog2(LINE_BYTES);
   localparam int DEF_SETS          = 8;
   localparam int DEF_ADDRESS_WIDTH = 32;

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int aw, input int sets);
      return aw - OFFSET_W - $clog2(sets);
   endfunction

   localparam int INDEX_W = index_w(DEF_SETS);
   localparam int TAG_W   = tag_w(DEF_ADDRESS_WIDTH, DEF_SETS);

   function automatic logic [1:0] word_sel(input logic [OFFSET_W-1:0] off);
      return off[3:2];
   endfunction

   function automatic logic [1:0] byte_sel(input logic [OFFSET_W-1:0] off);
      return off[1:0];
   endfunction

   // Zero-extended byte lane of a little-endian word.
   function automatic logic [31:0] byte_extract(input logic [31:0] w, input logic [1:0] b);
      return {24'b0, w[8*b +: 8]};
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read port, byte-enabled write port, fill completion.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int TAG_W = 25
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [$clog2(SETS)-1:0]              rd_index,
   output logic                                 rd_valid,
   output logic [TAG_W-1:0]                     rd_tag,
   output logic [WORDS_PER_LINE-1:0][31:0]      rd_line,
   input  logic                                 wr_en,
   input  logic [$clog2(SETS)-1:0]              wr_index,
   input  logic [1:0]                           wr_word,
   input  logic [3:0]                           wr_be,
   input  logic [31:0]                          wr_data,
   input  logic                                 fill_done,
   input  logic [TAG_W-1:0]                     fill_tag
);

   logic [SETS-1:0]                    valid;
   logic [TAG_W-1:0]                   tags [SETS];
   logic [WORDS_PER_LINE-1:0][31:0]    data [SETS];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_line  = data[rd_index];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= '0;
      else if (fill_done)
         valid[wr_index] <= 1'b1;
   end

   // Tag and data contents are meaningless until valid is set, so no reset.
   always_ff @(posedge clk) begin
      if (fill_done)
         tags[wr_index] <= fill_tag;
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b])
               data[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-beat line refill.
module data_cache
   import dcache_pkg::*;
#(
   parameter int SETS          = 8,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0]    WD,
   input  logic                     WE,
   input  logic                     RE,
   input  logic                     ADTP,
   output logic [DATA_WIDTH-1:0]    RD,
   output logic                     stall,
   output logic [ADDRESS_WIDTH-1:0] mem_A,
   output logic [DATA_WIDTH-1:0]    mem_WD,
   output logic                     mem_WE,
   output logic                     mem_ADTP,
   input  logic [DATA_WIDTH-1:0]    mem_RD
);

   localparam int IW = index_w(SETS);
   localparam int TW = tag_w(ADDRESS_WIDTH, SETS);

   logic [ADDRESS_WIDTH-1:0]  a_eff;
   logic [IW-1:0]             idx;
   logic [TW-1:0]             tg;
   logic [OFFSET_W-1:0]       off;

   assign a_eff = ADTP ? A : {A[ADDRESS_WIDTH-1:2], 2'b00};
   assign idx   = a_eff[OFFSET_W +: IW];
   assign tg    = a_eff[ADDRESS_WIDTH-1 -: TW];
   assign off   = a_eff[OFFSET_W-1:0];

   state_t                    state, state_n;
   logic [1:0]                cnt, cnt_n;
   logic [IW-1:0]             lat_idx, lat_idx_n;
   logic [TW-1:0]             lat_tag, lat_tag_n;

   logic                      rd_valid;
   logic [TW-1:0]             rd_tag;
   logic [WORDS_PER_LINE-1:0][31:0] rd_line;
   logic                      hit;
   logic [31:0]               sel_word;

   logic                      wr_en, fill_done;
   logic [IW-1:0]             wr_index;
   logic [1:0]                wr_word;
   logic [3:0]                wr_be;
   logic [31:0]               wr_data;

   logic                      stall_c, mem_we_c, mem_adtp_c;
   logic [DATA_WIDTH-1:0]     rd_c, mem_wd_c;
   logic [ADDRESS_WIDTH-1:0]  mem_a_c;

   dcache_line_store #(.SETS(SETS), .TAG_W(TW)) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_en     (wr_en),
      .wr_index  (wr_index),
      .wr_word   (wr_word),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .fill_done (fill_done),
      .fill_tag  (lat_tag)
   );

   assign hit      = rd_valid && (rd_tag == tg);
   assign sel_word = rd_line[word_sel(off)];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         lat_idx <= '0;
         lat_tag <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         lat_idx <= lat_idx_n;
         lat_tag <= lat_tag_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      lat_idx_n  = lat_idx;
      lat_tag_n  = lat_tag;
      stall_c    = 1'b0;
      rd_c       = '0;
      mem_a_c    = A;
      mem_wd_c   = WD;
      mem_we_c   = 1'b0;
      mem_adtp_c = 1'b0;
      wr_en      = 1'b0;
      wr_index   = idx;
      wr_word    = word_sel(off);
      wr_be      = 4'h0;
      wr_data    = WD;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            if (RE) begin
               if (hit) begin
                  rd_c = ADTP ? byte_extract(sel_word, byte_sel(off)) : sel_word;
               end else begin
                  stall_c   = 1'b1;
                  lat_idx_n = idx;
                  lat_tag_n = tg;
                  cnt_n     = 2'd0;
                  state_n   = REFILL;
               end
            end else if (WE) begin
               mem_a_c    = a_eff;
               mem_we_c   = 1'b1;
               mem_adtp_c = ADTP;
               // Write-through: cached copy only follows the store on a hit.
               if (hit) begin
                  wr_en   = 1'b1;
                  wr_be   = ADTP ? (4'b0001 << byte_sel(off)) : 4'hF;
                  wr_data = ADTP ? {4{WD[7:0]}} : WD;
               end
            end
         end
         REFILL: begin
            stall_c  = 1'b1;
            mem_a_c  = {lat_tag, lat_idx, cnt, 2'b00};
            wr_en    = 1'b1;
            wr_index = lat_idx;
            wr_word  = cnt;
            wr_be    = 4'hF;
            wr_data  = mem_RD;
            cnt_n    = cnt + 2'd1;
            if (cnt == 2'd3) begin
               fill_done = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of the request inputs.
   assign stall    = rst_n & stall_c;
   assign RD       = rst_n ? rd_c : '0;
   assign mem_A    = rst_n ? mem_a_c : '0;
   assign mem_WD   = rst_n ? mem_wd_c : '0;
   assign mem_WE   = rst_n & mem_we_c;
   assign mem_ADTP = rst_n & mem_adtp_c;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench: directed test-plan scenarios plus random loads/stores vs. a line-level model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] A = '0, WD = '0;
   logic        WE = 1'b0, RE = 1'b0, ADTP = 1'b0;
   logic [31:0] RD, mem_A, mem_WD, mem_RD;
   logic        stall, mem_WE, mem_ADTP;

   int pass_cnt = 0;
   int total_cnt = 0;

   data_cache #(.SETS(8), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RE(RE), .ADTP(ADTP),
      .RD(RD), .stall(stall), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
      .mem_ADTP(mem_ADTP), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;

   // Memory seen by the DUT: byte i of each 4 KB window starts as i[7:0].
   logic [7:0] mem [4096];
   bit         mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
         mem_init <= 1'b1;
      end else if (mem_WE) begin
         if (mem_ADTP) mem[mem_A[11:0]] <= mem_WD[7:0];
         else begin
            mem[{mem_A[11:2], 2'd0}] <= mem_WD[7:0];
            mem[{mem_A[11:2], 2'd1}] <= mem_WD[15:8];
            mem[{mem_A[11:2], 2'd2}] <= mem_WD[23:16];
            mem[{mem_A[11:2], 2'd3}] <= mem_WD[31:24];
         end
      end
   end
   assign mem_RD = {mem[{mem_A[11:2], 2'd3}], mem[{mem_A[11:2], 2'd2}],
                    mem[{mem_A[11:2], 2'd1}], mem[{mem_A[11:2], 2'd0}]};

   // Reference: byte memory plus which 16-byte block each of the 8 lines holds.
   logic [7:0]  ref_mem [4096];
   bit          m_valid [8];
   int unsigned m_block [8];

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int unsigned b;
      b = (a & 32'hFFC) ;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic do_load(input logic [31:0] a, input logic adtp, input string nm,
                          input bit chk_const, input logic [31:0] cexp, input int cstall);
      int unsigned set, blk;
      logic [31:0] exp, w;
      int n, exp_n;
      blk = a / 16;
      set = blk % 8;
      exp_n = (m_valid[set] && m_block[set] == blk) ? 0 : 5;
      w = ref_word(a);
      exp = adtp ? {24'b0, ref_mem[a & 32'hFFF]} : w;
      RE = 1'b1; WE = 1'b0; A = a; ADTP = adtp;
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      total_cnt++;
      if (n !== exp_n) $display("FAIL %s stall_cycles addr=%h got %0d expected %0d", nm, a, n, exp_n);
      else pass_cnt++;
      if (cstall >= 0) begin
         total_cnt++;
         if (n !== cstall) $display("FAIL %s stall_const addr=%h got %0d expected %0d", nm, a, n, cstall);
         else pass_cnt++;
      end
      total_cnt++;
      if (RD !== exp) $display("FAIL %s rd addr=%h got %h expected %h", nm, a, RD, exp);
      else pass_cnt++;
      if (chk_const) begin
         total_cnt++;
         if (RD !== cexp) $display("FAIL %s rd_const addr=%h got %h expected %h", nm, a, RD, cexp);
         else pass_cnt++;
      end
      m_valid[set] = 1'b1;
      m_block[set] = blk;
      @(posedge clk); #1;
      RE = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic adtp, input logic [31:0] d, input string nm);
      logic [31:0] ea;
      ea = adtp ? a : (a & ~32'h3);
      WE = 1'b1; RE = 1'b0; A = a; ADTP = adtp; WD = d;
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0 || mem_WE !== 1'b1 || mem_A !== ea || mem_WD !== d || mem_ADTP !== adtp)
         $display("FAIL %s store_bus got stall=%b we=%b a=%h wd=%h t=%b expected 0 1 %h %h %b",
                  nm, stall, mem_WE, mem_A, mem_WD, mem_ADTP, ea, d, adtp);
      else pass_cnt++;
      if (adtp) ref_mem[a & 32'hFFF] = d[7:0];
      else for (int b = 0; b < 4; b++) ref_mem[(ea & 32'hFFF) + b] = d[8*b +: 8];
      @(posedge clk); #1;
      WE = 1'b0;
   endtask

   task automatic test_reset();
      RE = 1'b1; A = 32'h10004; WD = 32'h12345678;
      #2;
      total_cnt++;
      if (stall !== 1'b0 || RD !== 32'h0 || mem_WE !== 1'b0 || mem_ADTP !== 1'b0 ||
          mem_A !== 32'h0 || mem_WD !== 32'h0)
         $display("FAIL reset_outputs got stall=%b rd=%h we=%b t=%b a=%h wd=%h expected all zero",
                  stall, RD, mem_WE, mem_ADTP, mem_A, mem_WD);
      else pass_cnt++;
      RE = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (stall !== 1'b0 || mem_WE !== 1'b0 || mem_A !== A)
         $display("FAIL idle_quiet got stall=%b we=%b a=%h expected 0 0 %h", stall, mem_WE, mem_A, A);
      else pass_cnt++;
   endtask

   task automatic test_cold_miss();
      do_load(32'h10004, 1'b0, "cold_miss", 1'b1, 32'h07060504, 5);
      do_load(32'h1000C, 1'b0, "line_hit", 1'b1, 32'h0F0E0D0C, 0);
   endtask

   task automatic test_byte_load();
      do_load(32'h10009, 1'b1, "byte_hit", 1'b1, 32'h00000009, 0);
   endtask

   task automatic test_store_hit();
      do_store(32'h10004, 1'b0, 32'hDEADBEEF, "store_word");
      do_load(32'h10004, 1'b0, "store_readback", 1'b1, 32'hDEADBEEF, 0);
      do_store(32'h10005, 1'b1, 32'h000000AA, "store_byte");
      do_load(32'h10004, 1'b0, "byte_readback", 1'b1, 32'hDEADAAEF, 0);
   endtask

   task automatic test_store_miss();
      do_store(32'h10100, 1'b0, 32'hCAFEF00D, "store_miss");
      do_load(32'h10100, 1'b0, "after_store_miss", 1'b1, 32'hCAFEF00D, 5);
   endtask

   task automatic test_conflict();
      do_load(32'h10000, 1'b0, "conflict_a", 1'b0, 32'h0, 5);
      do_load(32'h10080, 1'b0, "conflict_b", 1'b1, 32'h83828180, 5);
      do_load(32'h10000, 1'b0, "conflict_a_again", 1'b0, 32'h0, 5);
   endtask

   task automatic test_reset_mid_refill();
      RE = 1'b1; WE = 1'b0; A = 32'h10244; ADTP = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL midreset_detect stall got %b expected 1", stall);
      else pass_cnt++;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      RE = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b0 || RD !== 32'h0 || mem_WE !== 1'b0 || mem_A !== 32'h0)
         $display("FAIL midreset_outputs got stall=%b rd=%h we=%b a=%h expected 0 0 0 0",
                  stall, RD, mem_WE, mem_A);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_load(32'h10244, 1'b0, "after_midreset", 1'b0, 32'h0, 5);
      do_load(32'h10004, 1'b0, "after_midreset_old", 1'b0, 32'h0, 5);
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      int op;
      for (int i = 0; i < 150; i++) begin
         a  = 32'h10000 + $urandom_range(0, 511);
         d  = $urandom;
         op = $urandom_range(0, 3);
         case (op)
            0: do_load(a & ~32'h3, 1'b0, "rand_load_w", 1'b0, 32'h0, -1);
            1: do_load(a, 1'b1, "rand_load_b", 1'b0, 32'h0, -1);
            2: do_store(a, 1'b0, d, "rand_store_w");
            default: do_store(a, 1'b1, d, "rand_store_b");
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i);
      for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_block[i] = 0; end
      test_reset();
      test_cold_miss();
      test_byte_load();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_reset_mid_refill();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the core's load/store datapath and the byte-addressed data memory. It serves word and byte loads from a small line store. On a read miss it stalls the core and refills one 16-byte line from memory, one word per cycle. Stores always go straight through to memory and update the cached copy on a hit.

## Interface
- SETS, 8, number of lines (power of two).
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width (fixed at 32).
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- A  in  ADDRESS_WIDTH  core byte address.
- WD  in  DATA_WIDTH  core store data.
- WE  in  1  core store request.
- RE  in  1  core load request. WE and RE are never both high.
- ADTP  in  1  access type: 0 = 32-bit word, 1 = byte (zero-extended on load).
- RD  out  DATA_WIDTH  load data.
- stall  out  1  hold the core; request inputs stay stable while high.
- mem_A  out  ADDRESS_WIDTH  memory byte address.
- mem_WD  out  DATA_WIDTH  memory write data.
- mem_WE  out  1  memory write enable.
- mem_ADTP  out  1  memory access type.
- mem_RD  in  DATA_WIDTH  memory read data, combinational from mem_A.

## Operation
- Address split:
  - offset = A[3:0] (word select A[3:2], byte select A[1:0]).
  - index = A[4 +: log2(SETS)].
  - tag = remaining upper bits.
- Word accesses force A[1:0] to 00 on both the cache and memory side.
- Per-line state: valid bit, tag, 4 words. Hit = valid[index] && tag match.
- FSM states: IDLE and REFILL. There is also a 2-bit refill counter `cnt`.
- **IDLE, RE hit:** RD = selected word, or {24'b0, selected byte}. stall = 0.
- **IDLE, RE miss:** stall = 1. Latch index and tag. Go to REFILL with cnt = 0.
- **IDLE, WE:**
  - Drive mem_A = A, mem_WD = WD, mem_WE = 1, mem_ADTP = ADTP. stall = 0.
  - On a hit, update the cached word (ADTP = 0) or the single byte (ADTP = 1) at the clock edge.
  - On a miss, cache state is unchanged.
- **REFILL:**
  - stall = 1, mem_WE = 0, mem_ADTP = 0, mem_A = {latched tag, index, cnt, 2'b00}.
  - Each edge writes mem_RD into line word cnt, then increments cnt.
  - On the edge with cnt = 3: set valid, write tag, return to IDLE. The retried load then hits.
- RD = 0 whenever RE = 0 or stall = 1.
- The memory side is idle (mem_WE = 0, mem_A = A) when IDLE with no store.
- No replacement policy is needed: the refill overwrites the indexed line unconditionally.

## Timing
- Load hit: zero added latency; RD is valid in the same cycle as RE.
- Load miss:
  - stall is high in cycle N (detection) and in the 4 REFILL cycles N+1..N+4.
  - Data is returned with stall = 0 in cycle N+5.
  - Miss penalty is 5 cycles.
- Store: single cycle, never stalls, memory write at the same edge as any cache update.
- A store arriving while stall is high is held by the core, so it cannot collide with a refill.
- Reset (asynchronous, at any time including mid-REFILL):
  - All valid bits clear, state = IDLE, cnt = 0. Partially refilled lines stay invalid.
  - Output values while rst_n = 0: stall = 0, RD = 0, mem_WE = 0, mem_ADTP = 0, mem_A = 0, mem_WD = 0.
- Data and tag arrays need no reset.
- Index wrap: address 0x10000 and address 0x10000 + 16*SETS map to the same line. The second access evicts the first.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, REFILL);
  - LINE_BYTES = 16 and WORDS_PER_LINE = 4;
  - the offset, index and tag width localparams, derived from SETS;
  - the address-field extraction functions.
- Sub-module dcache_line_store: valid/tag/data arrays, one combinational read port, and one write port with word/byte enables. The FSM and memory mux stay in data_cache.

## Test plan
- **Cold read miss:** memory 0x10000..0x1000F = 00..0F, RE word at A = 0x10004. Required: stall high for 5 cycles, then RD = 0x07060504. A following read at 0x1000C hits with RD = 0x0F0E0D0C and no stall.
- **Byte load hit:** after the above, RE, ADTP = 1, A = 0x10009. Required: RD = 0x00000009 with stall = 0.
- **Store hit:**
  - WE word, A = 0x10004, WD = 0xDEADBEEF. Required: mem_WE = 1 that cycle with mem_A = 0x10004.
  - A subsequent read of 0x10004 hits and returns 0xDEADBEEF.
  - A byte store of 0xAA at 0x10005 then reads back 0xDEADAAEF.
- **Store miss:** WE to 0x10100, which is not cached. Required: a memory write occurs, there is no stall, and a later read of 0x10100 misses.
- **Conflict eviction:** read 0x10000, then read 0x10080 (SETS = 8). Required: both miss; rereading 0x10000 misses again.
- **Reset mid-refill:** assert rst_n = 0 at refill cycle 2. Required: stall = 0 immediately. After release, reading the same address performs a full 5-cycle miss.
